// File: rtl/id_control_stage_pkg.sv
// Shared encodings for the ID control stage and the downstream ALU control decoder.
// Both ends import this package so opcode, ALUOp and Funct values cannot drift apart.
package id_control_stage_pkg;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    // Funct is {instr[30], funct3}
    localparam logic [3:0] FUNCT_ADD = 4'b0000;
    localparam logic [3:0] FUNCT_SUB = 4'b1000;
    localparam logic [3:0] FUNCT_AND = 4'b0111;
    localparam logic [3:0] FUNCT_OR  = 4'b0110;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
        logic branch;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    function automatic logic [3:0] funct_of(input logic [31:0] instr);
        return {instr[30], instr[14:12]};
    endfunction

    function automatic logic rtype_funct_legal(input logic [3:0] funct);
        logic ok;
        case (funct)
            FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR: ok = 1'b1;
            default:                                   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/id_control_stage_imm_gen.sv
// Immediate generator: picks the I/S/B field layout from the opcode and sign-extends
// from instr[31]; R-type and unknown opcodes produce zero.
module imm_gen
    import id_control_stage_pkg::*;
(
    input  logic [31:0] instr,
    output logic [63:0] imm
);

    logic [6:0] opcode;
    logic       sign;
    logic       unused_fields;

    assign opcode = instr[6:0];
    assign sign   = instr[31];
    // rs1 and funct3 never contribute to an immediate
    assign unused_fields = ^instr[19:12];

    always_comb begin
        imm = '0;
        case (opcode)
            OPC_LOAD, OPC_OPIMM: imm = {{52{sign}}, instr[31:20]};
            OPC_STORE:           imm = {{52{sign}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:          imm = {{51{sign}}, instr[31], instr[7],
                                        instr[30:25], instr[11:8], 1'b0};
            default:             imm = '0;
        endcase
    end

endmodule

// File: rtl/id_control_stage.sv
// ID-stage control decode with a one-cycle ID/EX output register, bubble/stall/flush
// handling, a sticky illegal-instruction flag and a count of loaded instructions.
module id_control_stage
    import id_control_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_id_instr,
    input  logic        if_id_valid,
    input  logic        stall,
    input  logic        flush,
    output logic [1:0]  ALUOp,
    output logic [3:0]  Funct,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        ALUSrc,
    output logic        Branch,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [63:0] imm,
    output logic        id_ex_valid,
    output logic        illegal_sticky,
    output logic [31:0] instr_count
);

    logic [6:0]  dec_opcode;
    logic [3:0]  dec_funct;
    logic [63:0] dec_imm;
    ctrl_t       dec_ctrl;
    alu_op_e     dec_alu_op;
    logic        dec_legal;

    alu_op_e     alu_op_q,  alu_op_d;
    logic [3:0]  funct_q,   funct_d;
    ctrl_t       ctrl_q,    ctrl_d;
    logic [4:0]  rs1_q,     rs1_d;
    logic [4:0]  rs2_q,     rs2_d;
    logic [4:0]  rd_q,      rd_d;
    logic [63:0] imm_q,     imm_d;
    logic        valid_q,   valid_d;
    logic        sticky_q,  sticky_d;
    logic [31:0] instr_count_q, instr_count_d;

    assign dec_opcode = if_id_instr[6:0];
    assign dec_funct  = funct_of(if_id_instr);

    imm_gen u_imm_gen (
        .instr (if_id_instr),
        .imm   (dec_imm)
    );

    always_comb begin
        dec_ctrl   = CTRL_NONE;
        dec_alu_op = ALUOP_ADD;
        dec_legal  = 1'b1;
        case (dec_opcode)
            OPC_RTYPE: begin
                dec_ctrl.reg_write = 1'b1;
                dec_alu_op         = ALUOP_FUNCT;
                // only instr[30] of funct7 may be set
                dec_legal = (if_id_instr[31] == 1'b0) &&
                            (if_id_instr[29:25] == 5'b00000) &&
                            rtype_funct_legal(dec_funct);
            end
            OPC_LOAD: begin
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.mem_read   = 1'b1;
                dec_ctrl.mem_to_reg = 1'b1;
                dec_ctrl.alu_src    = 1'b1;
            end
            OPC_STORE: begin
                dec_ctrl.mem_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
            end
            OPC_BRANCH: begin
                dec_ctrl.branch = 1'b1;
                dec_alu_op      = ALUOP_SUB;
            end
            OPC_OPIMM: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_src   = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Next-state selection: flush beats stall beats load; reset is handled in the register.
    always_comb begin
        alu_op_d      = alu_op_q;
        funct_d       = funct_q;
        ctrl_d        = ctrl_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        rd_d          = rd_q;
        imm_d         = imm_q;
        valid_d       = valid_q;
        sticky_d      = sticky_q;
        instr_count_d = instr_count_q;

        if (flush || (!stall && !(if_id_valid && dec_legal))) begin
            alu_op_d = ALUOP_ADD;
            funct_d  = '0;
            ctrl_d   = CTRL_NONE;
            rs1_d    = '0;
            rs2_d    = '0;
            rd_d     = '0;
            imm_d    = '0;
            valid_d  = 1'b0;
            if (!flush && if_id_valid) begin
                sticky_d = 1'b1;
            end
        end else if (!stall) begin
            alu_op_d      = dec_alu_op;
            funct_d       = dec_funct;
            ctrl_d        = dec_ctrl;
            rs1_d         = if_id_instr[19:15];
            rs2_d         = if_id_instr[24:20];
            rd_d          = if_id_instr[11:7];
            imm_d         = dec_imm;
            valid_d       = 1'b1;
            instr_count_d = instr_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            alu_op_q      <= ALUOP_ADD;
            funct_q       <= '0;
            ctrl_q        <= CTRL_NONE;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rd_q          <= '0;
            imm_q         <= '0;
            valid_q       <= 1'b0;
            sticky_q      <= 1'b0;
            instr_count_q <= '0;
        end else begin
            alu_op_q      <= alu_op_d;
            funct_q       <= funct_d;
            ctrl_q        <= ctrl_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            rd_q          <= rd_d;
            imm_q         <= imm_d;
            valid_q       <= valid_d;
            sticky_q      <= sticky_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign ALUOp          = alu_op_q;
    assign Funct          = funct_q;
    assign RegWrite       = ctrl_q.reg_write;
    assign MemRead        = ctrl_q.mem_read;
    assign MemWrite       = ctrl_q.mem_write;
    assign MemtoReg       = ctrl_q.mem_to_reg;
    assign ALUSrc         = ctrl_q.alu_src;
    assign Branch         = ctrl_q.branch;
    assign rs1            = rs1_q;
    assign rs2            = rs2_q;
    assign rd             = rd_q;
    assign imm            = imm_q;
    assign id_ex_valid    = valid_q;
    assign illegal_sticky = sticky_q;
    assign instr_count    = instr_count_q;

endmodule

// File: tb/tb_id_control_stage.sv
// Directed plus randomized bench for id_control_stage, checked against a behavioural
// model of the decode table, bubble/stall/flush priority and the counters.
module tb_id_control_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        stall;
    logic        flush;
    logic [1:0]  ALUOp;
    logic [3:0]  Funct;
    logic        RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] imm;
    logic        id_ex_valid;
    logic        illegal_sticky;
    logic [31:0] instr_count;

    always #5 clk = ~clk;

    id_control_stage dut (
        .clk            (clk),
        .reset          (reset),
        .if_id_instr    (if_id_instr),
        .if_id_valid    (if_id_valid),
        .stall          (stall),
        .flush          (flush),
        .ALUOp          (ALUOp),
        .Funct          (Funct),
        .RegWrite       (RegWrite),
        .MemRead        (MemRead),
        .MemWrite       (MemWrite),
        .MemtoReg       (MemtoReg),
        .ALUSrc         (ALUSrc),
        .Branch         (Branch),
        .rs1            (rs1),
        .rs2            (rs2),
        .rd             (rd),
        .imm            (imm),
        .id_ex_valid    (id_ex_valid),
        .illegal_sticky (illegal_sticky),
        .instr_count    (instr_count)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference state: what the ID/EX outputs should hold after each edge.
    logic [1:0]  m_alu;
    logic [3:0]  m_funct;
    logic [5:0]  m_ctrl;    // {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch}
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [63:0] m_imm;
    logic        m_vld, m_sticky;
    logic [31:0] m_cnt;

    logic [6:0] opc_tab [5] = '{7'h33, 7'h03, 7'h23, 7'h63, 7'h13};

    task automatic model_bubble();
        m_alu = '0; m_funct = '0; m_ctrl = '0;
        m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_imm = '0; m_vld = 1'b0;
    endtask

    task automatic model_step(input logic [31:0] ins, input logic v, input logic st,
                              input logic fl, input logic rn);
        logic        ok;
        logic [1:0]  a;
        logic [5:0]  c;
        logic [63:0] im;
        if (!rn) begin
            model_bubble();
            m_sticky = 1'b0;
            m_cnt    = '0;
            return;
        end
        if (fl) begin
            model_bubble();
            return;
        end
        if (st) return;
        if (!v) begin
            model_bubble();
            return;
        end
        ok = 1'b1; a = 2'd0; c = 6'b0; im = '0;
        case (ins[6:0])
            7'h33: begin
                a  = 2'd2;
                c  = 6'b100000;
                ok = (ins[31:25] == 7'h00 && ins[14:12] inside {3'd0, 3'd6, 3'd7}) ||
                     (ins[31:25] == 7'h20 && ins[14:12] == 3'd0);
            end
            7'h03: begin
                c  = 6'b110110;
                im = 64'($signed(ins[31:20]));
            end
            7'h23: begin
                c  = 6'b001010;
                im = 64'($signed({ins[31:25], ins[11:7]}));
            end
            7'h63: begin
                a  = 2'd1;
                c  = 6'b000001;
                im = 64'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            end
            7'h13: begin
                c  = 6'b100010;
                im = 64'($signed(ins[31:20]));
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            model_bubble();
            m_sticky = 1'b1;
            return;
        end
        m_alu   = a;
        m_funct = {ins[30], ins[14:12]};
        m_ctrl  = c;
        m_rs1   = ins[19:15];
        m_rs2   = ins[24:20];
        m_rd    = ins[11:7];
        m_imm   = im;
        m_vld   = 1'b1;
        m_cnt   = m_cnt + 32'd1;
    endtask

    task automatic check_all(input string tag);
        logic [124:0] got, exp;
        got = {ALUOp, Funct, RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch,
               rs1, rs2, rd, imm, id_ex_valid, illegal_sticky, instr_count};
        exp = {m_alu, m_funct, m_ctrl, m_rs1, m_rs2, m_rd, m_imm, m_vld, m_sticky, m_cnt};
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [31:0] ins, input logic v,
                        input logic st, input logic fl, input logic rn);
        if_id_instr = ins;
        if_id_valid = v;
        stall       = st;
        flush       = fl;
        reset       = rn;
        @(posedge clk);
        #1;
        model_step(ins, v, st, fl, rn);
        check_all(tag);
    endtask

    localparam logic [31:0] I_ADD = 32'h002081B3;
    localparam logic [31:0] I_SUB = 32'h407302B3;
    localparam logic [31:0] I_LD  = 32'h00813203;
    localparam logic [31:0] I_BEQ = 32'hFE208CE3;

    initial begin
        logic [31:0] ins;
        logic [6:0]  f7;
        int          k;

        model_bubble();
        m_sticky    = 1'b0;
        m_cnt       = '0;
        reset       = 1'b0;
        if_id_instr = '0;
        if_id_valid = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;

        step("reset0", I_ADD, 1'b1, 1'b1, 1'b0, 1'b0);
        step("reset1", I_SUB, 1'b1, 1'b0, 1'b1, 1'b0);
        check_val("reset_count", 64'(instr_count), 64'd0);

        step("add", I_ADD, 1'b1, 1'b0, 1'b0, 1'b1);
        check_val("add_aluop", 64'(ALUOp), 64'h2);
        check_val("add_funct", 64'(Funct), 64'h0);
        check_val("add_regs", 64'({RegWrite, rs1, rs2, rd}), 64'({1'b1, 5'd1, 5'd2, 5'd3}));
        check_val("add_imm", imm, 64'h0);
        check_val("add_count", 64'(instr_count), 64'd1);

        step("sub", I_SUB, 1'b1, 1'b0, 1'b0, 1'b1);
        check_val("sub_funct_aluop", 64'({Funct, ALUOp}), 64'({4'b1000, 2'b10}));

        step("ld", I_LD, 1'b1, 1'b0, 1'b0, 1'b1);
        check_val("ld_ctrl", 64'({ALUOp, MemRead, MemtoReg, ALUSrc}), 64'({2'b00, 3'b111}));
        check_val("ld_imm", imm, 64'h8);

        step("beq", I_BEQ, 1'b1, 1'b0, 1'b0, 1'b1);
        check_val("beq_ctrl", 64'({ALUOp, Branch, RegWrite}), 64'({2'b01, 1'b1, 1'b0}));
        check_val("beq_imm", imm, 64'hFFFF_FFFF_FFFF_FFF8);

        step("add_pre_stall", I_ADD, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step("stall_hold", I_SUB, 1'b1, 1'b1, 1'b0, 1'b1);
            check_val("stall_count", 64'(instr_count), 64'd5);
        end
        step("stall_flush", I_SUB, 1'b1, 1'b1, 1'b1, 1'b1);
        check_val("stall_flush_valid", 64'(id_ex_valid), 64'd0);

        step("bubble_in", I_ADD, 1'b0, 1'b0, 1'b0, 1'b1);
        step("illegal_allones", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
        check_val("illegal_sticky", 64'({illegal_sticky, id_ex_valid}), 64'({1'b1, 1'b0}));
        check_val("illegal_count", 64'(instr_count), 64'd5);
        step("illegal_stalled", 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1);
        step("illegal_rtype_and_hi", 32'h4020F1B3, 1'b1, 1'b0, 1'b0, 1'b1);
        step("legal_after_illegal", I_LD, 1'b1, 1'b0, 1'b0, 1'b1);
        check_val("sticky_persists", 64'(illegal_sticky), 64'd1);

        for (int n = 0; n < 400; n++) begin
            k   = $urandom_range(0, 6);
            ins = $urandom();
            if (k < 5) ins[6:0] = opc_tab[k];
            if (k == 0) begin
                case ($urandom_range(0, 3))
                    0: f7 = 7'h00;
                    1: f7 = 7'h20;
                    default: f7 = 7'($urandom());
                endcase
                ins[31:25] = f7;
            end
            step("random", ins, ($urandom_range(0, 9) != 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 59) != 0));
        end

        step("pre_wrap", I_ADD, 1'b1, 1'b0, 1'b0, 1'b1);
        force dut.instr_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.instr_count_q;
        m_cnt = 32'hFFFF_FFFF;
        step("wrap_load", I_SUB, 1'b1, 1'b0, 1'b0, 1'b1);
        check_val("wrap_count", 64'(instr_count), 64'd0);

        step("reset_with_stall", I_ADD, 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("reset_stall_all", 64'({ALUOp, Funct, RegWrite, MemRead, MemWrite, MemtoReg,
                  ALUSrc, Branch, rs1, rs2, rd, id_ex_valid, illegal_sticky}) | imm |
                  64'(instr_count), 64'd0);
        step("first_after_reset", I_ADD, 1'b1, 1'b0, 1'b0, 1'b1);
        check_val("first_after_reset_count", 64'(instr_count), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
